// File: rtl/dmux4_dispatch_ctrl_if.sv
// Handshake bundle for the 4-way dispatch controller: upstream beat stream plus
// one-hot sink valids, per-sink readies, shared payload and busy flag.
interface dmux4_dispatch_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             rr_mode;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, in_sel, rr_mode, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_sel, rr_mode, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/dmux4_dispatch_ctrl.sv
// Purpose: registers one beat and steers it to one of 4 sinks (explicit select or ready-aware round-robin).
// Latency: beat accepted at edge N is valid at a sink during cycle N+1; 1 beat/cycle when the target is ready.
// Backpressure: in_ready = ~hold | out_ready[tgt]; a stalled beat holds data/target. DMUX4_DISPATCH_STATS_EN adds per-sink counters.
module dmux4_dispatch_ctrl #(
  parameter int WIDTH = 8
`ifdef DMUX4_DISPATCH_STATS_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dmux4_dispatch_ctrl_if.slave   bus
`ifdef DMUX4_DISPATCH_STATS_EN
  , input  logic                 stats_clr
  , output logic [4*CNT_W-1:0]   stats_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       tgt;
  logic [1:0]       rr_ptr;
  logic [1:0]       rr_pick;
  logic [1:0]       rr_idx;
  logic             rr_found;
  logic [1:0]       next_tgt;
  logic [3:0]       vld_q;
  logic [WIDTH-1:0] data_q;
  logic             hold_v;
  logic             xfer;
  logic             consume;

  assign hold_v       = (state == HOLD);
  assign consume      = hold_v & bus.out_ready[tgt];
  assign bus.in_ready = ~hold_v | bus.out_ready[tgt];
  assign xfer         = bus.in_valid & bus.in_ready;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.busy      = hold_v;

  // First ready sink after rr_ptr; falls back to rr_ptr+1 when no sink is ready.
  always_comb begin
    rr_pick  = rr_ptr + 2'd1;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      rr_idx = rr_ptr + 2'(k);
      if (!rr_found && bus.out_ready[rr_idx]) begin
        rr_pick  = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  assign next_tgt = bus.rr_mode ? rr_pick : bus.in_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tgt    <= 2'd0;
      rr_ptr <= 2'd3;
      vld_q  <= 4'b0000;
      data_q <= '0;
    end else begin
      case (state)
        IDLE:    if (xfer) state <= HOLD;
        HOLD:    if (consume && !xfer) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (xfer) begin
        data_q <= bus.in_data;
        tgt    <= next_tgt;
        vld_q  <= 4'b0001 << next_tgt;
        if (bus.rr_mode) rr_ptr <= rr_pick;
      end else if (consume) begin
        vld_q <= 4'b0000;
      end
    end
  end

`ifdef DMUX4_DISPATCH_STATS_EN
  logic [CNT_W-1:0] cnt [4];

  for (genvar i = 0; i < 4; i++) begin : g_stats
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt[i] <= '0;
      end else if (stats_clr) begin
        cnt[i] <= '0;
      end else if (vld_q[i] && bus.out_ready[i] && (cnt[i] != {CNT_W{1'b1}})) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
    assign stats_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_dmux4_dispatch_ctrl.sv
// Directed bench for dmux4_dispatch_ctrl: reset, explicit select, stall, streaming,
// round-robin, async reset while holding, and counters when DMUX4_DISPATCH_STATS_EN is set.
module tb_dmux4_dispatch_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  dmux4_dispatch_ctrl_if #(.WIDTH(8)) bus ();

`ifdef DMUX4_DISPATCH_STATS_EN
  logic       stats_clr;
  logic [7:0] stats_cnt;

  dmux4_dispatch_ctrl #(.WIDTH(8), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .stats_clr (stats_clr),
    .stats_cnt (stats_cnt)
  );
`else
  dmux4_dispatch_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_tgt [8];

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_sel    = 2'd0;
    bus.rr_mode   = 1'b0;
    bus.out_ready = 4'b0000;
`ifdef DMUX4_DISPATCH_STATS_EN
    stats_clr = 1'b0;
`endif

    // Reset
    cyc(); cyc();
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Single explicit-select beat to sink 2
    bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 8'hA5; bus.out_ready = 4'b1111;
    #1;
    check("t2_in_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    bus.in_valid = 1'b0;
    #1;
    check("t2_out_valid", 32'(bus.out_valid), 32'h4);
    check("t2_out_data", 32'(bus.out_data), 32'hA5);
    check("t2_busy", 32'(bus.busy), 32'h1);
    cyc();
    check("t2_drained", 32'(bus.out_valid), 32'h0);
    check("t2_idle_busy", 32'(bus.busy), 32'h0);

    // Stall on sink 1; changed inputs during the stall must not disturb the beat
    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'h3C; bus.out_ready = 4'b1101;
    cyc();
    bus.in_sel = 2'd3; bus.in_data = 8'hFF; bus.rr_mode = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t3_stall_valid", 32'(bus.out_valid), 32'h2);
      check("t3_stall_data", 32'(bus.out_data), 32'h3C);
      check("t3_stall_in_ready", 32'(bus.in_ready), 32'h0);
      cyc();
    end
    bus.in_valid = 1'b0; bus.rr_mode = 1'b0; bus.out_ready = 4'b1111;
    #1;
    check("t3_release_in_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    check("t3_consumed", 32'(bus.out_valid), 32'h0);

    // Back-to-back explicit beats to sinks 0..3
    bus.in_valid = 1'b1; bus.out_ready = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      bus.in_sel = 2'(s); bus.in_data = 8'(8'h10 + s);
      #1;
      check("t4_in_ready", 32'(bus.in_ready), 32'h1);
      cyc();
      check("t4_out_valid", 32'(bus.out_valid), 32'(4'b0001 << s));
      check("t4_out_data", 32'(bus.out_data), 32'(8'h10 + s));
    end
    bus.in_valid = 1'b0;
    cyc();
    check("t4_drained", 32'(bus.out_valid), 32'h0);

    // Round-robin, all sinks ready: 0,1,2,3,0 (pointer starts at 3)
    exp_tgt[0] = 4'b0001; exp_tgt[1] = 4'b0010; exp_tgt[2] = 4'b0100;
    exp_tgt[3] = 4'b1000; exp_tgt[4] = 4'b0001;
    bus.rr_mode = 1'b1; bus.in_valid = 1'b1; bus.in_sel = 2'd2;
    for (int b = 0; b < 5; b++) begin
      bus.in_data = 8'(8'h50 + b);
      cyc();
      check("t5_rr_all", 32'(bus.out_valid), 32'(exp_tgt[b]));
    end
    bus.in_valid = 1'b0;
    cyc();
    // Round-robin with sinks 1 and 3 ready: 1,3,1
    exp_tgt[5] = 4'b0010; exp_tgt[6] = 4'b1000; exp_tgt[7] = 4'b0010;
    bus.out_ready = 4'b1010; bus.in_valid = 1'b1;
    for (int b = 5; b < 8; b++) begin
      cyc();
      check("t5_rr_partial", 32'(bus.out_valid), 32'(exp_tgt[b]));
    end
    bus.in_valid = 1'b0;
    cyc();
    check("t5_drained", 32'(bus.out_valid), 32'h0);

    // Async reset while holding a stalled beat
    bus.rr_mode = 1'b0; bus.in_sel = 2'd3; bus.in_data = 8'h77; bus.out_ready = 4'b0000;
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    #1;
    check("t1_hold_valid", 32'(bus.out_valid), 32'h8);
    rst_n = 1'b0;
    #1;
    check("t1_async_valid", 32'(bus.out_valid), 32'h0);
    check("t1_async_busy", 32'(bus.busy), 32'h0);
    cyc();
    rst_n = 1'b1;
    // Pointer back at 3 after reset, so the first round-robin beat goes to sink 0
    bus.rr_mode = 1'b1; bus.out_ready = 4'b1111; bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    #1;
    check("t1_rr_after_rst", 32'(bus.out_valid), 32'h1);
    cyc();

`ifdef DMUX4_DISPATCH_STATS_EN
    bus.rr_mode = 1'b0;
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    check("t6_cleared", 32'(stats_cnt[1:0]), 32'h0);
    bus.in_valid = 1'b1; bus.in_sel = 2'd0;
    for (int b = 0; b < 5; b++) cyc();
    bus.in_valid = 1'b0;
    cyc();
    check("t6_saturated", 32'(stats_cnt[1:0]), 32'h3);
    check("t6_sink1_untouched", 32'(stats_cnt[3:2]), 32'h0);
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    check("t6_clr_priority", 32'(stats_cnt[1:0]), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
